// File: rtl/bram_word_master.sv
// Byte-serial initiator for the byte-wide single-port bram: splits byte/half/word
// loads and stores into big-endian byte accesses and assembles/extends load data.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | waiting for a request, o_ready high
// S_RD_ISSUE | presenting load byte addresses, one per cycle
// S_RD_DRAIN | last address held, waiting for the final read byte
// S_WR       | presenting store bytes with o_mem_write high, MSB first
// S_DONE     | one-cycle completion, can accept the next request
module bram_word_master #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_data,
  output logic                  o_mem_write,
  input  logic [7:0]            i_mem_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_DRAIN, S_WR, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            last_q, last_d;
  logic                  signed_q, signed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            mdata_q, mdata_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  write_q, write_d;
  logic                  accept;
  logic [31:0]           word;
  logic [31:0]           aligned;

  // Index of the final byte: 0 for byte, 1 for half, 3 for word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  assign accept = i_req & ready_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      mdata_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      mdata_q  <= mdata_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      write_q  <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = i_we ? S_WR : S_RD_ISSUE;
        else        state_d = S_IDLE;
      end
      S_RD_ISSUE: if (cnt_q == last_q) state_d = S_RD_DRAIN;
      S_RD_DRAIN: state_d = S_DONE;
      S_WR:       if (cnt_q == last_q) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    last_d   = last_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    mdata_d  = mdata_q;
    word     = {shift_q[23:0], i_mem_data};
    aligned  = '0;
    ready_d  = (state_d == S_IDLE) || (state_d == S_DONE);
    done_d   = (state_d == S_DONE);
    write_d  = (state_d == S_WR);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          addr_d   = i_addr;
          cnt_d    = 2'd0;
          last_d   = last_idx(i_size);
          signed_d = i_signed;
          // Left-justify store data so the first byte out is always [31:24].
          case (last_idx(i_size))
            2'd0:    aligned = {i_wdata[7:0], 24'h0};
            2'd1:    aligned = {i_wdata[15:0], 16'h0};
            default: aligned = i_wdata;
          endcase
          if (i_we) begin
            mdata_d = aligned[31:24];
            shift_d = {aligned[23:0], 8'h0};
          end else begin
            shift_d = '0;
          end
        end
      end
      S_RD_ISSUE: begin
        // Read data lags the address by one cycle, so capture starts at cnt 1.
        if (cnt_q != 2'd0) shift_d = word;
        if (cnt_q != last_q) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q + 2'd1;
        end
      end
      S_RD_DRAIN: begin
        case (last_q)
          2'd0:    rdata_d = {{24{word[7] & signed_q}}, word[7:0]};
          2'd1:    rdata_d = {{16{word[15] & signed_q}}, word[15:0]};
          default: rdata_d = word;
        endcase
      end
      S_WR: begin
        if (cnt_q != last_q) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q + 2'd1;
          mdata_d = shift_q[31:24];
          shift_d = {shift_q[23:0], 8'h0};
        end
      end
      default: ;
    endcase
  end

  assign o_ready     = ready_q;
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_data  = mdata_q;
  assign o_mem_write = write_q;

endmodule

// File: doc/bram_word_master.md
Name: bram_word_master

Overview:
- Bus-side initiator for the byte-wide single-port `bram`.
- Converts one byte/halfword/word load or store from the core into a sequence of byte accesses on the BRAM port.
- Assembles and sign/zero-extends read data into 32 bits.
- Byte order is big-endian: the lowest address holds the most significant byte, matching how program words are laid out in BRAM.

Parameters:
- ADDR_WIDTH, 12, byte address width of the attached BRAM (BRAM DATA_WIDTH fixed at 8).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous reset, active-high
- i_req  in  1  request strobe; accepted when i_req & o_ready at a rising edge
- i_we  in  1  1 = store, 0 = load (sampled on accept)
- i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = word (sampled on accept)
- i_signed  in  1  load sign-extension enable for byte/half (sampled on accept)
- i_addr  in  ADDR_WIDTH  start byte address (sampled on accept)
- i_wdata  in  32  store data, right-aligned (sampled on accept)
- o_ready  out  1  high when idle and able to accept
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  load result; valid while o_done high, held until next load completes
- o_mem_addr  out  ADDR_WIDTH  to bram i_addr
- o_mem_data  out  8  to bram i_data
- o_mem_write  out  1  to bram i_write
- i_mem_data  in  8  from bram o_data (1-cycle registered read latency)

Behaviour:
- Reset (i_rst high at an edge):
  - State goes to IDLE; o_ready=1, o_done=0, o_rdata=0, o_mem_write=0, o_mem_addr=0, o_mem_data=0.
  - Reset wins over any simultaneous request.
- All outputs are registered.
- N = 1/2/4 bytes for size 0/1/2-3. Byte k (k=0..N-1) goes to address (i_addr + k) mod 2^ADDR_WIDTH.
- Wrap-around is silent. No alignment check; misaligned accesses are legal.
- States: IDLE, RD_ISSUE, RD_DRAIN, WR, DONE. A byte counter (2 bits) and a 32-bit shift register are required.
- Acceptance edge E0 (IDLE, i_req=1): latch the request and move to RD_ISSUE or WR. o_ready drops after E0.
- Load path:
  - After edge E(k), o_mem_addr = addr+k for k=0..N-1, with o_mem_write=0.
  - BRAM returns byte k after E(k+1); it is shifted into the assembly register at E(k+2).
  - After issuing the last byte, hold o_mem_addr and enter RD_DRAIN until the final byte is captured at E(N+1).
  - At E(N+1), o_rdata is updated and the block enters DONE: o_done=1 for exactly the cycle after E(N+1).
  - Latency: word = 5 cycles, half = 3, byte = 2.
- Extension rules:
  - Byte load: o_rdata = {24{b7 & i_signed}, byte}.
  - Half load: o_rdata = {16{b15 & i_signed}, half}.
  - Word load: i_signed is ignored.
- Store path:
  - After E(k), o_mem_write=1, o_mem_addr=addr+k, o_mem_data = i_wdata[8(N-k)-1 -: 8] (MSB first). BRAM writes byte k at E(k+1).
  - At E(N): o_mem_write=0, enter DONE, o_done=1. Latency: word = 4 cycles, half = 2, byte = 1.
  - o_rdata is unchanged by stores.
- DONE state:
  - o_ready=1 and o_done=1 for one cycle.
  - A request presented in the DONE cycle is accepted (back-to-back, no bubble). Otherwise the block returns to IDLE.
- o_mem_write is never high in IDLE, RD_ISSUE, RD_DRAIN or DONE.
- i_req while o_ready=0 is ignored and not queued. Request inputs may change freely after acceptance.
- Reset mid-operation:
  - The operation is aborted with no o_done pulse.
  - Bytes already written stay in BRAM. o_mem_write is low from the reset edge on.
  - Partial load data is discarded and o_rdata becomes 0.

Test Plan:
1. Preload mem[0..3] = FF,D0,07,93; word load at addr 0 -> o_done exactly 5 cycles after accept, o_rdata = 32'hFFD00793, o_mem_write never high.
2. mem[0x10] = 8'hFF: byte load, signed -> 32'hFFFFFFFF; unsigned -> 32'h000000FF. Half load at 0x10 with mem[0x11]=8'h80, signed -> 32'hFFFFFF80... Correction: the half is 16'hFF80, so signed -> 32'hFFFFFF80 and unsigned -> 32'h0000FF80.
3. Half store 32'h1234ABCD at 0x100 -> mem[0x100]=AB, mem[0x101]=CD, mem[0x102] untouched, o_done 2 cycles after accept. A word load from 0x100 issued in the o_done cycle is accepted immediately.
4. Word load at addr 2^ADDR_WIDTH-2 with mem[FFE,FFF,0,1] = 11,22,33,44 -> o_rdata = 32'h11223344 (address wrap).
5. Word store 32'hDEADBEEF at 0x20, i_rst pulsed after 2 write cycles -> mem[0x20]=DE, mem[0x21]=AD, mem[0x22..0x23] unchanged; no o_done; o_ready=1 and o_mem_write=0 the cycle after reset.
6. i_req pulsed repeatedly during a busy word load -> ignored; exactly one o_done; the later request is accepted only when o_ready=1.
